add_round_key: RTL and testbench

- Round-key addition stage sitting directly upstream of sub_bytes in the AES-128 encrypt datapath.
- Latches a 128-bit cipher key and expands it on the fly, one round key per processed state. No stored key table.
- For each accepted state it registers state XOR current round key and presents the result to sub_bytes with a one-cycle ready pulse.
- Tracks round number 0..10 so the controller knows when to skip mix_columns and when the block is finished.

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/key_expand_step.sv | 41 ++++
 rtl/s_box.sv | 19 +
 rtl/add_round_key.sv | 103 ++++++++++
 tb/tb_add_round_key.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// ============================================================================
// Module : aes_pkg
// Brief  : Shared AES-128 types, round constants and S-box arithmetic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package aes_pkg;

   localparam int AES_NR = 10;

   typedef logic [127:0] aes_block_t;
   typedef logic [31:0]  aes_word_t;

   localparam logic [7:0] AES_RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] p;
      logic [7:0] e;
      r = 8'h01;
      p = a;
      e = 8'hfe;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = gf_mul(r, p);
         p = gf_mul(p, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

endpackage

`default_nettype wire

// File: rtl/key_expand_step.sv
// ============================================================================
// Module : key_expand_step
// Brief  : Combinational AES-128 key schedule step: round key K -> next key.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_expand_step
   import aes_pkg::*;
(
   input  aes_block_t k,
   input  logic [7:0] rc,
   output aes_block_t next_k
);

   aes_word_t w_w0, w_w1, w_w2, w_w3;
   aes_word_t w_rot, w_sub, w_t;
   aes_word_t w_n0, w_n1, w_n2, w_n3;

   assign {w_w0, w_w1, w_w2, w_w3} = k;
   assign w_rot = {w_w3[23:0], w_w3[31:24]};

   generate
      for (genvar g = 0; g < 4; g++) begin : g_sub
         s_box u_sbox (
            .a (w_rot[8*g +: 8]),
            .y (w_sub[8*g +: 8])
         );
      end
   endgenerate

   assign w_t  = w_sub ^ {rc, 24'h000000};
   assign w_n0 = w_w0 ^ w_t;
   assign w_n1 = w_w1 ^ w_n0;
   assign w_n2 = w_w2 ^ w_n1;
   assign w_n3 = w_w3 ^ w_n2;
   assign next_k = {w_n0, w_n1, w_n2, w_n3};

endmodule

`default_nettype wire

// File: rtl/s_box.sv
// ============================================================================
// Module : s_box
// Brief  : Combinational AES forward S-box for one byte.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module s_box
   import aes_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);

   assign y = sbox_calc(a);

endmodule

`default_nettype wire

// File: rtl/add_round_key.sv
// ============================================================================
// Module : add_round_key
// Brief  : AES-128 round-key addition with on-the-fly key expansion.
//          Option AES_KEY_ZEROIZE_EN: wipe the key after the round-10 accept.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module add_round_key
   import aes_pkg::*;
#(
   parameter int NR = AES_NR
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         load_key,
   input  logic [127:0]                 key_in,
   input  logic                         in_valid,
   input  logic [127:0]                 state_in,
   output logic [127:0]                 out,
   output logic                         ark_ready,
   output logic [$clog2(NR+1)-1:0]      round_idx,
   output logic                         last_round,
   output logic                         done,
   output logic                         seq_err
);

   localparam int             RW     = $clog2(NR + 1);
   localparam logic [RW-1:0]  c_last = RW'(NR);
   localparam logic [RW-1:0]  c_one  = RW'(1);

   aes_block_t    r_rk;
   logic [RW-1:0] r_rcnt;
   logic          r_key_loaded;
   logic          r_done;

   aes_block_t    w_key;
   aes_block_t    w_next_rk;
   logic [RW-1:0] w_rcnt;
   logic [RW-1:0] w_rc_idx;
   logic [7:0]    w_rc;
   logic          w_accept;

   // A concurrent load_key behaves as if the new key were already latched.
   assign w_key    = load_key ? key_in : r_rk;
   assign w_rcnt   = load_key ? '0 : r_rcnt;
   assign w_accept = in_valid & (load_key | (r_key_loaded & ~r_done));
   assign w_rc_idx = (w_rcnt == c_last) ? c_last : w_rcnt + c_one;
   assign w_rc     = AES_RCON[w_rc_idx];

   key_expand_step u_step (
      .k      (w_key),
      .rc     (w_rc),
      .next_k (w_next_rk)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out          <= '0;
         ark_ready    <= 1'b0;
         round_idx    <= '0;
         last_round   <= 1'b0;
         done         <= 1'b0;
         seq_err      <= 1'b0;
         r_rk         <= '0;
         r_rcnt       <= '0;
         r_key_loaded <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         out        <= w_accept ? (state_in ^ w_key) : '0;
         ark_ready  <= w_accept;
         last_round <= w_accept && (w_rcnt == c_last);
         if (w_accept) round_idx <= w_rcnt;

         if (load_key) begin
            r_rk         <= key_in;
            r_rcnt       <= '0;
            r_done       <= 1'b0;
            done         <= 1'b0;
            r_key_loaded <= 1'b1;
         end

         if (w_accept) begin
            if (w_rcnt == c_last) begin
               r_done <= 1'b1;
               done   <= 1'b1;
`ifdef AES_KEY_ZEROIZE_EN
               r_rk         <= '0;
               r_key_loaded <= 1'b0;
`endif
            end else begin
               r_rk   <= w_next_rk;
               r_rcnt <= w_rcnt + c_one;
            end
         end

         if (in_valid && !w_accept) seq_err <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_add_round_key.sv
// ============================================================================
// Module : tb_add_round_key
// Brief  : Self-checking bench for add_round_key against a key-schedule model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_add_round_key;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         load_key;
   logic [127:0] key_in;
   logic         in_valid;
   logic [127:0] state_in;
   logic [127:0] out;
   logic         ark_ready;
   logic [3:0]   round_idx;
   logic         last_round;
   logic         done;
   logic         seq_err;

   add_round_key dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_key   (load_key),
      .key_in     (key_in),
      .in_valid   (in_valid),
      .state_in   (state_in),
      .out        (out),
      .ark_ready  (ark_ready),
      .round_idx  (round_idx),
      .last_round (last_round),
      .done       (done),
      .seq_err    (seq_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]   sbox [0:255];
   logic [127:0] m_keys [0:10];
   int           m_r;
   bit           m_loaded, m_done, m_seq, m_zero;
   logic [127:0] e_out;
   bit           e_rdy, e_last;
   int           e_idx;

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   function automatic logic [7:0] rl(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   // S-box table built by walking generator 3 and its inverse in lockstep.
   task automatic build_sbox();
      logic [7:0] p, q;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         sbox[p] = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4) ^ 8'h63;
      end while (p != 8'h01);
      sbox[0] = 8'h63;
   endtask

   task automatic sched(input logic [127:0] k);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic cyc(input bit ld, input logic [127:0] k, input bit v,
                      input logic [127:0] s, input bit rn);
      bit acc;
      rst_n = rn; load_key = ld; key_in = k; in_valid = v; state_in = s;
      if (!rn) begin
         for (int r = 0; r <= 10; r++) m_keys[r] = '0;
         m_r = 0; m_loaded = 0; m_done = 0; m_seq = 0; m_zero = 0;
         e_out = '0; e_rdy = 0; e_last = 0; e_idx = 0;
      end else begin
         if (ld) begin
            sched(k);
            m_r = 0; m_done = 0; m_loaded = 1; m_zero = 0;
         end
         acc = v && m_loaded && !m_done;
         e_rdy = acc;
         e_out = acc ? (s ^ m_keys[m_r]) : '0;
         e_last = acc && (m_r == 10);
         if (acc) begin
            e_idx = m_r;
            if (m_r == 10) begin
               m_done = 1;
`ifdef AES_KEY_ZEROIZE_EN
               m_loaded = 0; m_zero = 1;
`endif
            end else begin
               m_r++;
            end
         end else if (v) begin
            m_seq = 1;
         end
      end
      @(posedge clk);
      #1;
      chk("out", out, e_out);
      chk("ark_ready", 128'(ark_ready), 128'(e_rdy));
      chk("last_round", 128'(last_round), 128'(e_last));
      chk("done", 128'(done), 128'(m_done));
      chk("seq_err", 128'(seq_err), 128'(m_seq));
      if (e_rdy || !rn) chk("round_idx", 128'(round_idx), 128'(e_idx));
      chk("rk", dut.r_rk, m_zero ? 128'h0 : m_keys[m_r]);
   endtask

   initial begin
      rst_n = 0; load_key = 0; key_in = '0; in_valid = 0; state_in = '0;
      build_sbox();

      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      // Known-answer vector from the AES standard.
      cyc(1, KEY_B, 0, 0, 1);
      cyc(0, 0, 1, 128'h3243f6a8885a308d313198a2e0370734, 1);
      chk("fips_out", out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);

      // Eleven zero states expose the full round-key sequence.
      cyc(1, KEY_B, 0, 0, 1);
      for (int r = 0; r <= 10; r++) begin
         cyc(0, 0, 1, 0, 1);
         if (r == 1)  chk("rk1_out", out, 128'ha0fafe1788542cb123a339392a6c7605);
         if (r == 10) chk("rk10_out", out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      end
      chk("done_after", 128'(done), 128'd1);
`ifdef AES_KEY_ZEROIZE_EN
      chk("rk_final", dut.r_rk, 128'h0);
`else
      chk("rk_final", dut.r_rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif

      // Overrun after done, then reload keeps the sticky error.
      cyc(0, 0, 1, rnd128(), 1);
      chk("overrun_err", 128'(seq_err), 128'd1);
      cyc(1, rnd128(), 0, 0, 1);
      chk("err_sticky", 128'(seq_err), 128'd1);

      // Simultaneous load_key and in_valid mid-sequence.
      for (int r = 0; r < 4; r++) cyc(0, 0, 1, rnd128(), 1);
      cyc(1, rnd128(), 1, rnd128(), 1);
      chk("sim_idx", 128'(round_idx), 128'd0);
      cyc(0, 0, 1, rnd128(), 1);

      // Reset in the middle of a sequence drops the in-flight accept.
      cyc(1, rnd128(), 0, 0, 1);
      for (int r = 0; r < 5; r++) cyc(0, 0, 1, rnd128(), 1);
      cyc(0, 0, 1, rnd128(), 0);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 1, rnd128(), 1);
      chk("nokey_err", 128'(seq_err), 128'd1);

      // Randomized traffic.
      cyc(0, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 15) == 0), rnd128(), ($urandom_range(0, 3) != 0),
             rnd128(), ($urandom_range(0, 99) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
